alu_result_fifo: RTL and testbench

- Downstream stage of the 12-bit ALU: captures every valid ALU result (o_valid/o_data/o_overflow) into a small synchronous FIFO.
- Presents the results to the consumer (accumulator write-back / host readout) over a valid/ready handshake.
- Decouples the free-running ALU, which has no back-pressure, from a consumer that can stall.
- Counts overflowed results, and counts results dropped because the FIFO was full.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/sat_counter.sv | 26 ++
 rtl/alu_result_fifo.sv | 124 ++++++++++++
 tb/tb_alu_result_fifo.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, instruction encodings, result record and
// saturation limits used by the ALU and its downstream stages.
package alu_pkg;

  localparam int ALU_DATA_W = 12;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_AND    = 3'b010;
  localparam logic [2:0] OP_OR     = 3'b011;
  localparam logic [2:0] OP_XOR    = 3'b100;
  localparam logic [2:0] OP_SHL    = 3'b101;
  localparam logic [2:0] OP_SHR    = 3'b110;
  localparam logic [2:0] OP_ABSMAX = 3'b111;

  typedef struct packed {
    logic                  ovf;
    logic [ALU_DATA_W-1:0] data;
  } alu_result_t;

  localparam logic [ALU_DATA_W-1:0] SAT_MAX = 12'h7FF;
  localparam logic [ALU_DATA_W-1:0] SAT_MIN = 12'h800;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count up on i_inc until the all-ones ceiling is reached.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= {W{1'b0}};
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/alu_result_fifo.sv
// Show-ahead result FIFO behind the free-running ALU, with overflow/drop counters.
// Define ALU_RESULT_FIFO_SAT_EN to store overflowed results clamped to the signed range.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_overflow,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_overflow,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [CNT_W-1:0]         o_ovf_cnt,
  output logic [CNT_W-1:0]         o_drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W:0]   r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_valid;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic [DATA_W:0]   w_wr_entry;
  logic [DATA_W:0]   w_head;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == {CW{1'b0}});
  assign w_valid = ~w_empty;
  assign w_pop   = w_valid & i_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push  = i_valid & (~w_full | w_pop);
  assign w_drop  = i_valid & w_full & ~w_pop;

  // Build the {overflow, data} word to store.
  always_comb begin
    w_wr_entry = {i_overflow, i_data};
`ifdef ALU_RESULT_FIFO_SAT_EN
    if (i_overflow) begin
      // Wrapped sign is opposite to the true sign: negative wrap means positive overflow.
      if (i_data[DATA_W-1]) begin
        w_wr_entry = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
      end else begin
        w_wr_entry = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
      end
    end else begin
      w_wr_entry = {i_overflow, i_data};
    end
`endif
  end

  // Storage write; contents need no reset because occupancy gates the outputs.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      r_wr_ptr <= w_push ? (r_wr_ptr + PW'(1)) : r_wr_ptr;
      r_rd_ptr <= w_pop  ? (r_rd_ptr + PW'(1)) : r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Show-ahead head entry, forced to zero while empty.
  always_comb begin
    if (w_valid) begin
      w_head = r_mem[r_rd_ptr];
    end else begin
      w_head = {(DATA_W+1){1'b0}};
    end
  end

  sat_counter #(.W(CNT_W)) u_ovf_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (w_push & w_wr_entry[DATA_W]),
    .o_cnt (o_ovf_cnt)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (w_drop),
    .o_cnt (o_drop_cnt)
  );

  assign o_valid    = w_valid;
  assign o_data     = w_head[DATA_W-1:0];
  assign o_overflow = w_head[DATA_W];
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_count    = r_count;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo at default parameters.
module tb_alu_result_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [11:0] in_data;
  logic        in_ovf;
  logic        ready;
  logic        out_valid;
  logic [11:0] out_data;
  logic        out_ovf;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic [7:0]  ovf_cnt;
  logic [7:0]  drop_cnt;

  int tests = 0;
  int fails = 0;

  alu_result_fifo dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (in_valid),
    .i_data     (in_data),
    .i_overflow (in_ovf),
    .i_ready    (ready),
    .o_valid    (out_valid),
    .o_data     (out_data),
    .o_overflow (out_ovf),
    .o_full     (full),
    .o_empty    (empty),
    .o_count    (count),
    .o_ovf_cnt  (ovf_cnt),
    .o_drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 12'h000; in_ovf = 1'b0; ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ovfcnt", 32'(ovf_cnt), 32'd0);
    chk("rst_dropcnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_empty", 32'(empty), 32'd1);

    // Three pushes with consumer stalled, then drain.
    in_valid = 1'b1; in_data = 12'h001; tick();
    chk("lat1_valid", 32'(out_valid), 32'd1);
    chk("lat1_data", 32'(out_data), 32'h001);
    in_data = 12'h7FE; tick();
    in_data = 12'h800; tick();
    in_valid = 1'b0;
    chk("p3_count", 32'(count), 32'd3);
    chk("stall_data", 32'(out_data), 32'h001);
    tick();
    chk("stall_hold", 32'(out_data), 32'h001);
    ready = 1'b1;
    chk("pop0", 32'(out_data), 32'h001);
    tick();
    chk("pop1", 32'(out_data), 32'h7FE);
    tick();
    chk("pop2", 32'(out_data), 32'h800);
    tick();
    chk("drain3_empty", 32'(empty), 32'd1);
    chk("drain3_valid", 32'(out_valid), 32'd0);
    chk("drain3_data", 32'(out_data), 32'd0);
    ready = 1'b0;

    // Ten pushes into an 8-deep FIFO: two drops.
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 12'h010 + 12'(i);
      tick();
      if (i == 6) chk("full_at7", 32'(full), 32'd0);
      if (i == 7) chk("full_at8", 32'(full), 32'd1);
    end
    chk("ovr_count", 32'(count), 32'd8);
    chk("ovr_drop", 32'(drop_cnt), 32'd2);

    // Full with push and pop together: no drop, count stays 8.
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 12'h020 + 12'(k);
      chk("fpp_head", 32'(out_data), 32'h010 + 32'(k));
      tick();
      chk("fpp_count", 32'(count), 32'd8);
    end
    chk("fpp_drop", 32'(drop_cnt), 32'd2);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("wrap_drain", 32'(out_data), (k < 4) ? (32'h014 + 32'(k)) : (32'h020 + 32'(k - 4)));
      tick();
    end
    chk("wrap_empty", 32'(empty), 32'd1);
    chk("wrap_drop", 32'(drop_cnt), 32'd2);
    ready = 1'b0;

    // Overflowed result.
    in_valid = 1'b1; in_data = 12'hF00; in_ovf = 1'b1; tick();
    in_valid = 1'b0; in_ovf = 1'b0;
    chk("ovf_cnt", 32'(ovf_cnt), 32'd1);
    chk("ovf_flag", 32'(out_ovf), 32'd1);
`ifdef ALU_RESULT_FIFO_SAT_EN
    chk("ovf_data", 32'(out_data), 32'h7FF);
`else
    chk("ovf_data", 32'(out_data), 32'hF00);
`endif
    ready = 1'b1; tick(); ready = 1'b0;
    chk("ovf_popped", 32'(empty), 32'd1);
    chk("ovf_flag0", 32'(out_ovf), 32'd0);

    // Reset mid-operation, then saturate the drop counter.
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 12'h100 + 12'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd5);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ovf", 32'(ovf_cnt), 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 268; i++) begin
      in_data = 12'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("sat_drop", 32'(drop_cnt), 32'd255);
    chk("sat_full", 32'(full), 32'd1);
    chk("sat_head", 32'(out_data), 32'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
